// File: rtl/ser_pkg.sv
// Shared serial-path definitions: FSM state encoding and default word width
// used by the serialiser, the complementer bench and the deserialiser.
package ser_pkg;
  localparam int SER_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;
endpackage

// File: rtl/par2ser_lsb.sv
// LSB-first parallel-to-serial shifter with valid/ready input and a word-start
// strobe on bit 0; back-to-back words stream with no idle cycle.
module par2ser_lsb
  import ser_pkg::*;
#(
  parameter int W = SER_W
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         ser_bit,
  output logic         ser_first,
  output logic         ser_valid,
  output logic         busy
);
  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  ser_state_e    state, state_nx;
  logic [W-1:0]  sh, sh_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept;

  // Ready on the last bit lets the next word load with no gap.
  assign din_ready = (state == ST_IDLE) || (state == ST_SHIFT && cnt == LAST);
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state <= ST_IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sh    <= sh_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          sh_nx    = din;
          cnt_nx   = '0;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt != LAST) begin
          sh_nx  = sh >> 1;
          cnt_nx = cnt + CW'(1);
        end else if (accept) begin
          sh_nx  = din;
          cnt_nx = '0;
        end else begin
          sh_nx    = '0;
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        sh_nx    = '0;
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign ser_valid = (state == ST_SHIFT);
  assign busy      = ser_valid;
  assign ser_bit   = ser_valid & sh[0];
  assign ser_first = ser_valid && (cnt == '0);
endmodule

// File: tb/tb_par2ser_lsb.sv
// Bench for par2ser_lsb: W=8 and W=2 instances checked every cycle against a
// queue-of-pending-bits reference model, plus directed stream checks.
module tb_par2ser_lsb;
  logic       clk = 1'b0;
  logic       r   = 1'b1;
  logic [7:0] din8 = '0;
  logic       v8   = 1'b0;
  logic [1:0] din2 = '0;
  logic       v2   = 1'b0;
  logic rdy8, bit8, first8, sv8, busy8;
  logic rdy2, bit2, first2, sv2, busy2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit b;
    bit f;
  } ent_t;

  // Each queue holds the bit currently on the wire followed by those still to come.
  ent_t q8[$];
  ent_t q2[$];

  always #5 clk = ~clk;

  par2ser_lsb #(.W(8)) dut8 (
    .clk(clk), .r(r), .din(din8), .din_valid(v8), .din_ready(rdy8),
    .ser_bit(bit8), .ser_first(first8), .ser_valid(sv8), .busy(busy8)
  );

  par2ser_lsb #(.W(2)) dut2 (
    .clk(clk), .r(r), .din(din2), .din_valid(v2), .din_ready(rdy2),
    .ser_bit(bit2), .ser_first(first2), .ser_valid(sv2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    chk("valid8", 32'(sv8),    32'(q8.size() > 0));
    chk("busy8",  32'(busy8),  32'(q8.size() > 0));
    chk("bit8",   32'(bit8),   32'(q8.size() > 0 ? q8[0].b : 1'b0));
    chk("first8", 32'(first8), 32'(q8.size() > 0 ? q8[0].f : 1'b0));
    chk("valid2", 32'(sv2),    32'(q2.size() > 0));
    chk("busy2",  32'(busy2),  32'(q2.size() > 0));
    chk("bit2",   32'(bit2),   32'(q2.size() > 0 ? q2[0].b : 1'b0));
    chk("first2", 32'(first2), 32'(q2.size() > 0 ? q2[0].f : 1'b0));
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step(input logic a8, input logic [7:0] d8, input logic a2, input logic [1:0] d2);
    logic acc8, acc2;
    v8 = a8; din8 = d8; v2 = a2; din2 = d2;
    #1;
    chk("ready8", 32'(rdy8), 32'(q8.size() <= 1));
    chk("ready2", 32'(rdy2), 32'(q2.size() <= 1));
    acc8 = a8 && (q8.size() <= 1) && !r;
    acc2 = a2 && (q2.size() <= 1) && !r;
    @(posedge clk);
    if (!r) begin
      if (q8.size() > 0) void'(q8.pop_front());
      if (q2.size() > 0) void'(q2.pop_front());
      if (acc8) for (int i = 0; i < 8; i++) q8.push_back('{d8[i], i == 0});
      if (acc2) for (int i = 0; i < 2; i++) q2.push_back('{d2[i], i == 0});
    end
    #1;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  cap;
    logic [15:0] cap16;
    logic [3:0]  cap2;
    logic [7:0]  f8;
    logic [3:0]  f2;
    logic        pend8, pend2, a8, a2, ok8, ok2;
    logic [7:0]  d8;
    logic [1:0]  d2;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid8", 32'(sv8), 0);
    chk("rst_bit8", 32'(bit8), 0);
    chk("rst_first8", 32'(first8), 0);
    chk("rst_ready8", 32'(rdy8), 1);
    r = 1'b0;

    // Basic word B5
    step(1, 8'hB5, 0, 0);
    cap[0] = bit8; f8[0] = first8;
    for (int i = 1; i < 8; i++) begin
      step(0, 8'h00, 0, 0);
      cap[i] = bit8; f8[i] = first8;
    end
    chk("t1_stream", 32'(cap), 32'h0000_00B5);
    chk("t1_first", 32'(f8), 32'h0000_0001);
    step(0, 8'h00, 0, 0);
    chk("t1_after_valid", 32'(sv8), 0);

    // Back-to-back 01 then 80 with valid held
    step(1, 8'h01, 0, 0);
    cap16[0] = bit8;
    for (int i = 1; i < 9; i++) begin
      step(1, 8'h80, 0, 0);
      cap16[i] = bit8;
      if (i == 8) chk("t2_first9", 32'(first8), 1);
    end
    for (int i = 9; i < 16; i++) begin
      step(0, 8'h00, 0, 0);
      cap16[i] = bit8;
    end
    chk("t2_stream", 32'(cap16), 32'h0000_8001);

    // Idle with din wiggling and valid low
    for (int i = 0; i < 10; i++) step(0, 8'($urandom), 0, 2'($urandom));

    // Reset mid-word
    step(1, 8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);
    #2 r = 1'b1;
    #1;
    chk("t4_valid", 32'(sv8), 0);
    chk("t4_bit", 32'(bit8), 0);
    chk("t4_first", 32'(first8), 0);
    chk("t4_busy", 32'(busy8), 0);
    chk("t4_ready", 32'(rdy8), 1);
    q8.delete();
    q2.delete();
    @(negedge clk);
    step(1, 8'hAA, 1, 2'b11);   // must not be accepted while r is high
    r = 1'b0;
    step(1, 8'h0F, 0, 0);
    cap[0] = bit8; f8[0] = first8;
    for (int i = 1; i < 8; i++) begin
      step(0, 8'h00, 0, 0);
      cap[i] = bit8; f8[i] = first8;
    end
    chk("t4_stream", 32'(cap), 32'h0000_000F);
    chk("t4_first_bits", 32'(f8), 32'h0000_0001);

    // Stream of 05 fed to a serial two's complementer yields FB
    step(1, 8'h05, 0, 0);
    cap[0] = bit8;
    for (int i = 1; i < 8; i++) begin
      step(0, 8'h00, 0, 0);
      cap[i] = bit8;
    end
    chk("t5_twos", 32'(8'(-cap)), 32'h0000_00FB);
    step(0, 8'h00, 0, 0);

    // Minimum width: 10 then 01 back-to-back
    step(0, 8'h00, 1, 2'b10); cap2[0] = bit2; f2[0] = first2;
    step(0, 8'h00, 1, 2'b01); cap2[1] = bit2; f2[1] = first2;
    step(0, 8'h00, 1, 2'b01); cap2[2] = bit2; f2[2] = first2;
    step(0, 8'h00, 0, 2'b00); cap2[3] = bit2; f2[3] = first2;
    chk("t6_stream", 32'(cap2), 32'h0000_0006);
    chk("t6_first", 32'(f2), 32'h0000_0005);

    // Random traffic, din held until accepted
    pend8 = 0; pend2 = 0; d8 = '0; d2 = '0; a8 = 0; a2 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pend8) begin a8 = 1'($urandom_range(0, 3) != 0); d8 = 8'($urandom); end
      if (!pend2) begin a2 = 1'($urandom_range(0, 3) != 0); d2 = 2'($urandom); end
      ok8 = (q8.size() <= 1);
      ok2 = (q2.size() <= 1);
      step(a8, d8, a2, d2);
      pend8 = a8 && !ok8;
      pend2 = a2 && !ok2;
    end
    for (int n = 0; n < 10; n++) step(0, 8'h00, 0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
